// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg
// Shared definitions for the instruction-memory loader:
//   - default frame sync byte and memory geometry
//   - FSM state encoding (3-bit)
//   - helper that validates a received frame length
// Optional feature macro: PROG_LOADER_CHECKSUM_EN (adds the CHK state).

package prog_loader_pkg;

    localparam int          ADDR_W_DEFAULT    = 10;
    localparam int          DATA_W_DEFAULT    = 16;
    localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;

    typedef logic [7:0] byte_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN_HI  = 3'd1,
        ST_LEN_LO  = 3'd2,
        ST_DATA_HI = 3'd3,
        ST_DATA_LO = 3'd4,
`ifdef PROG_LOADER_CHECKSUM_EN
        ST_CHK     = 3'd5,
`endif
        ST_DONE    = 3'd6,
        ST_ERR     = 3'd7
    } state_e;

    // A frame must carry at least one word and no more words than the
    // instruction memory holds, so the address can never wrap.
    function automatic logic len_ok(input logic [15:0] len, input int addr_w);
        return (len != 16'd0) && ({16'd0, len} <= (32'd1 << addr_w));
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// prog_loader_if
// Host byte-stream link feeding the loader.
//   in_valid : host byte valid          (master -> slave)
//   in_data  : host byte                (master -> slave)
//   in_ready : loader accepts the byte  (slave -> master)
// A byte transfers on a rising clock edge with in_valid && in_ready.

interface prog_loader_if;
    import prog_loader_pkg::*;

    logic  in_valid;
    byte_t in_data;
    logic  in_ready;

    modport master (output in_valid, output in_data, input  in_ready);
    modport slave  (input  in_valid, input  in_data, output in_ready);

endinterface

// File: rtl/prog_loader.sv
// prog_loader
// Writer side of the CPU instruction memory. Receives a framed byte stream
// (SYNC, LEN_HI, LEN_LO, 2*LEN data bytes[, CHK]) while holding the CPU in
// reset, packs byte pairs big-endian into 16-bit words, writes them to
// consecutive addresses and releases the CPU once the frame is complete.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   host        : byte stream (prog_loader_if.slave)
//   mem_we      : one-cycle write strobe per word
//   mem_addr    : word address
//   mem_wdata   : instruction word, first byte in [15:8]
//   cpu_rst     : CPU reset, low only while the program is loaded
//   done, error : load complete / frame rejected
//   word_count  : words written in the current or last frame
// Optional feature macro: PROG_LOADER_CHECKSUM_EN -- when defined a trailing
// XOR checksum byte over the data bytes is expected and checked.

module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int         ADDR_W    = ADDR_W_DEFAULT,
    parameter int         DATA_W    = DATA_W_DEFAULT,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    prog_loader_if.slave      host,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   word_count
);

    state_e      state_q, next_state;
    logic [15:0] len_q;
    byte_t       hi_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    byte_t       chk_q;
`endif
    logic        accept;
    logic        last_word;
    logic        flush;

    assign host.in_ready = ~rst;

    assign cpu_rst = (state_q != ST_DONE);
    assign done    = (state_q == ST_DONE);
    assign error   = (state_q == ST_ERR);

    // Next-state logic. Without the checksum, the last word's low byte keeps
    // the FSM in DATA_LO for one extra cycle (flush) so DONE follows the
    // final mem_we rather than coinciding with it; bytes offered during that
    // cycle are ignored.
    always_comb begin
        next_state = state_q;
        accept     = host.in_valid && host.in_ready;
        last_word  = ((word_count + 1'b1) == len_q[ADDR_W:0]);
        flush      = 1'b0;
`ifndef PROG_LOADER_CHECKSUM_EN
        flush      = (state_q == ST_DATA_LO) && mem_we;
`endif
        case (state_q)
            ST_IDLE:
                if (accept && host.in_data == SYNC_BYTE) next_state = ST_LEN_HI;
            ST_LEN_HI:
                if (accept) next_state = ST_LEN_LO;
            ST_LEN_LO:
                if (accept)
                    next_state = len_ok({len_q[15:8], host.in_data}, ADDR_W)
                                 ? ST_DATA_HI : ST_ERR;
            ST_DATA_HI:
                if (accept) next_state = ST_DATA_LO;
            ST_DATA_LO: begin
`ifdef PROG_LOADER_CHECKSUM_EN
                if (accept) next_state = last_word ? ST_CHK : ST_DATA_HI;
`else
                if (flush)       next_state = ST_DONE;
                else if (accept) next_state = last_word ? ST_DATA_LO : ST_DATA_HI;
`endif
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            ST_CHK:
                if (accept) next_state = (host.in_data == chk_q) ? ST_DONE : ST_ERR;
`endif
            ST_DONE, ST_ERR:
                if (accept && host.in_data == SYNC_BYTE) next_state = ST_LEN_HI;
            default:
                next_state = ST_IDLE;
        endcase
    end

    // State register plus the byte-packing datapath. mem_we is a registered
    // pulse raised by the low byte of each word; word_count doubles as the
    // write index.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            hi_q       <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            chk_q      <= '0;
`endif
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            word_count <= '0;
        end else begin
            state_q <= next_state;
            mem_we  <= 1'b0;
            case (state_q)
                ST_LEN_HI:
                    if (accept) len_q[15:8] <= host.in_data;
                ST_LEN_LO:
                    if (accept) begin
                        len_q[7:0] <= host.in_data;
                        if (next_state == ST_DATA_HI) begin
                            word_count <= '0;
                            mem_addr   <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                            chk_q      <= '0;
`endif
                        end
                    end
                ST_DATA_HI:
                    if (accept) begin
                        hi_q  <= host.in_data;
`ifdef PROG_LOADER_CHECKSUM_EN
                        chk_q <= chk_q ^ host.in_data;
`endif
                    end
                ST_DATA_LO:
                    if (accept && !flush) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                        chk_q      <= chk_q ^ host.in_data;
`endif
                        mem_we     <= 1'b1;
                        mem_wdata  <= DATA_W'({hi_q, host.in_data});
                        mem_addr   <= word_count[ADDR_W-1:0];
                        word_count <= word_count + 1'b1;
                    end
                default: ;
            endcase
        end
    end

endmodule
